// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared state encoding and sizing constants for the quiz buzzer core
package quiz_pkg;

    localparam int MAX_PLAYERS = 16;
    localparam int WHO_W       = $clog2(MAX_PLAYERS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/quiz_prio_enc.sv
// rtl/quiz_prio_enc.sv - combinational lowest-index-first encoder over the eligible buzz vector
module quiz_prio_enc
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS = 4
) (
    input  logic [N_PLAYERS-1:0] req,
    output logic [WHO_W-1:0]     index,
    output logic                 valid
);

    // Scanning high to low lets the lowest set bit overwrite last.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = WHO_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quiz_core.sv
// rtl/quiz_core.sv - quiz round FSM with buzzer lock-out, countdown and scoring; QUIZ_CORE_FOUL_EN adds false-start detection
module quiz_core
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int TIME_W    = 8,
    parameter int SCORE_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         tick,
    input  logic [N_PLAYERS-1:0]         buzz,
    input  logic                         yes,
    input  logic                         no,
    input  logic [TIME_W-1:0]            maxtime,
    input  logic [SCORE_W-1:0]           scorejia,
    input  logic [SCORE_W-1:0]           scorejian,
    output logic [1:0]                   state,
    output logic [3:0]                   who,
    output logic                         who_valid,
    output logic [TIME_W-1:0]            resttime,
    output logic                         timeout,
    output logic [N_PLAYERS*SCORE_W-1:0] score,
    output logic [N_PLAYERS-1:0]         foul
);

    state_t                state_q, state_d;
    logic [WHO_W-1:0]      who_q, who_d;
    logic                  who_valid_q, who_valid_d;
    logic [TIME_W-1:0]     rest_q, rest_d;
    logic                  timeout_q, timeout_d;
    logic [N_PLAYERS-1:0]  foul_q, foul_d;
    logic [SCORE_W-1:0]    score_q [N_PLAYERS];
    logic [SCORE_W-1:0]    score_d [N_PLAYERS];

    logic [N_PLAYERS-1:0]  eligible;
    logic [N_PLAYERS-1:0]  foul_set;
    logic [WHO_W-1:0]      hit_idx;
    logic                  hit_valid;

`ifdef QUIZ_CORE_FOUL_EN
    assign foul_set = buzz;
    assign eligible = buzz & ~foul_q;
`else
    assign foul_set = '0;
    assign eligible = buzz;
`endif

    quiz_prio_enc #(
        .N_PLAYERS (N_PLAYERS)
    ) u_prio_enc (
        .req   (eligible),
        .index (hit_idx),
        .valid (hit_valid)
    );

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        return (a < b) ? '0 : (a - b);
    endfunction

    always_comb begin
        state_d     = state_q;
        who_d       = who_q;
        who_valid_d = who_valid_q;
        rest_d      = rest_q;
        timeout_d   = 1'b0;
        foul_d      = foul_q;
        score_d     = score_q;

        case (state_q)
            IDLE: begin
                foul_d = foul_q | foul_set;
                if (start) begin
                    state_d = ARMED;
                    rest_d  = maxtime;
                end
            end
            ARMED: begin
                // A buzz in the same cycle as a tick takes priority and freezes the timer.
                if (hit_valid) begin
                    state_d     = LOCKED;
                    who_d       = hit_idx;
                    who_valid_d = 1'b1;
                end else if (tick) begin
                    if (rest_q == '0) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        foul_d    = '0;
                    end else begin
                        rest_d = rest_q - TIME_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Contradictory verdicts (both or neither) leave the round locked.
                if (yes ^ no) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (who_q == WHO_W'(i)) begin
                            score_d[i] = yes ? sat_add(score_q[i], scorejia)
                                             : sat_sub(score_q[i], scorejian);
                        end
                    end
                    state_d     = IDLE;
                    who_valid_d = 1'b0;
                    foul_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            who_q       <= '0;
            who_valid_q <= 1'b0;
            rest_q      <= '0;
            timeout_q   <= 1'b0;
            foul_q      <= '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            who_q       <= who_d;
            who_valid_q <= who_valid_d;
            rest_q      <= rest_d;
            timeout_q   <= timeout_d;
            foul_q      <= foul_d;
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_q[i] <= score_d[i];
            end
        end
    end

    assign state     = state_q;
    assign who       = who_q;
    assign who_valid = who_valid_q;
    assign resttime  = rest_q;
    assign timeout   = timeout_q;
    assign foul      = foul_q;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        assign score[g*SCORE_W +: SCORE_W] = score_q[g];
    end

endmodule

// File: tb/tb_quiz_core.sv
// tb/tb_quiz_core.sv - directed self-checking bench for quiz_core
module tb_quiz_core;

    localparam int N_PLAYERS = 4;
    localparam int TIME_W    = 8;
    localparam int SCORE_W   = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic                         tick;
    logic [N_PLAYERS-1:0]         buzz;
    logic                         yes;
    logic                         no;
    logic [TIME_W-1:0]            maxtime;
    logic [SCORE_W-1:0]           scorejia;
    logic [SCORE_W-1:0]           scorejian;
    logic [1:0]                   state;
    logic [3:0]                   who;
    logic                         who_valid;
    logic [TIME_W-1:0]            resttime;
    logic                         timeout;
    logic [N_PLAYERS*SCORE_W-1:0] score;
    logic [N_PLAYERS-1:0]         foul;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    quiz_core #(
        .N_PLAYERS (N_PLAYERS),
        .TIME_W    (TIME_W),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .buzz      (buzz),
        .yes       (yes),
        .no        (no),
        .maxtime   (maxtime),
        .scorejia  (scorejia),
        .scorejian (scorejian),
        .state     (state),
        .who       (who),
        .who_valid (who_valid),
        .resttime  (resttime),
        .timeout   (timeout),
        .score     (score),
        .foul      (foul)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sc(input int i);
        return 32'(score[i*SCORE_W +: SCORE_W]);
    endfunction

    // Advance one clock, sample 1 ns after the edge, then drop the pulse inputs.
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        tick  = 1'b0;
        yes   = 1'b0;
        no    = 1'b0;
        buzz  = '0;
    endtask

    task automatic play_round(input logic [3:0] b, input logic v_yes,
                              input logic [7:0] amount);
        start = 1'b1; maxtime = 8'd5; step();
        buzz = b; step();
        if (v_yes) begin yes = 1'b1; scorejia = amount; end
        else       begin no  = 1'b1; scorejian = amount; end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tick = 1'b0; buzz = '0; yes = 1'b0; no = 1'b0;
        maxtime = '0; scorejia = '0; scorejian = '0;
        step(); step();
        rst = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_who", 32'(who), 0);
        check("rst_who_valid", 32'(who_valid), 0);
        check("rst_resttime", 32'(resttime), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_score", 32'(score), 0);
        check("rst_foul", 32'(foul), 0);

        // Start, buzz player 2 at cycle 3.
        start = 1'b1; maxtime = 8'd5; step();
        check("arm_state", 32'(state), 1);
        check("arm_resttime", 32'(resttime), 5);
        step(); step();
        buzz = 4'b0100; step();
        check("lock_state", 32'(state), 2);
        check("lock_who", 32'(who), 2);
        check("lock_who_valid", 32'(who_valid), 1);
        check("lock_resttime", 32'(resttime), 5);
        start = 1'b1; buzz = 4'b0001; tick = 1'b1; step();
        check("locked_ignore_state", 32'(state), 2);
        check("locked_ignore_who", 32'(who), 2);
        check("locked_ignore_rest", 32'(resttime), 5);
        yes = 1'b1; no = 1'b1; scorejia = 8'd7; step();
        check("both_verdict_state", 32'(state), 2);
        check("both_verdict_score", 32'(score), 0);
        no = 1'b1; scorejian = 8'd1; step();
        check("no_floor_score2", sc(2), 0);
        check("no_idle", 32'(state), 0);
        check("no_who_valid", 32'(who_valid), 0);
        check("no_who_hold", 32'(who), 2);

        // Simultaneous buzz resolves to lowest index, then reward.
        start = 1'b1; maxtime = 8'd5; step();
        buzz = 4'b1010; step();
        check("multi_who", 32'(who), 1);
        yes = 1'b1; scorejia = 8'd3; step();
        check("yes_score1", sc(1), 3);
        check("yes_idle", 32'(state), 0);

        // Buzz and tick together: buzz wins, no decrement.
        start = 1'b1; maxtime = 8'd3; step();
        tick = 1'b1; step();
        check("tick_dec", 32'(resttime), 2);
        buzz = 4'b0001; tick = 1'b1; step();
        check("buzz_tick_state", 32'(state), 2);
        check("buzz_tick_who", 32'(who), 0);
        check("buzz_tick_rest", 32'(resttime), 2);
        check("buzz_tick_timeout", 32'(timeout), 0);
        yes = 1'b1; scorejia = 8'd254; step();
        check("score0_254", sc(0), 254);

        // Saturation at both ends.
        play_round(4'b0001, 1'b1, 8'd5);
        check("sat_hi_score0", sc(0), 255);
        play_round(4'b1000, 1'b1, 8'd2);
        check("score3_2", sc(3), 2);
        play_round(4'b1000, 1'b0, 8'd5);
        check("sat_lo_score3", sc(3), 0);

        // Countdown to timeout.
        start = 1'b1; maxtime = 8'd2; step();
        check("cd_rest2", 32'(resttime), 2);
        tick = 1'b1; step();
        check("cd_rest1", 32'(resttime), 1);
        tick = 1'b1; step();
        check("cd_rest0", 32'(resttime), 0);
        check("cd_still_armed", 32'(state), 1);
        tick = 1'b1; step();
        check("cd_timeout", 32'(timeout), 1);
        check("cd_idle", 32'(state), 0);
        step();
        check("cd_timeout_pulse", 32'(timeout), 0);
        check("cd_scores", 32'(score), 32'h00_00_03_FF);

        // Zero answer window.
        start = 1'b1; maxtime = 8'd0; step();
        check("zero_armed", 32'(state), 1);
        tick = 1'b1; step();
        check("zero_timeout", 32'(timeout), 1);
        check("zero_idle", 32'(state), 0);

        yes = 1'b1; scorejia = 8'd9; step();
        check("yes_idle_ignored", 32'(score), 32'h00_00_03_FF);

        // False start.
        buzz = 4'b1000; step();
`ifdef QUIZ_CORE_FOUL_EN
        check("foul_set", 32'(foul), 4'b1000);
`else
        check("foul_off", 32'(foul), 0);
`endif
        start = 1'b1; maxtime = 8'd5; step();
        buzz = 4'b1001; step();
        check("foul_who", 32'(who), 0);
        no = 1'b1; scorejian = 8'd0; step();
        check("foul_clear", 32'(foul), 0);
        check("foul_idle", 32'(state), 0);

        // Reset wins over a same-cycle verdict.
        start = 1'b1; maxtime = 8'd5; step();
        buzz = 4'b0010; step();
        check("pre_rst_locked", 32'(state), 2);
        rst = 1'b1; yes = 1'b1; scorejia = 8'd3; step();
        rst = 1'b0;
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_who", 32'(who), 0);
        check("mid_rst_who_valid", 32'(who_valid), 0);
        check("mid_rst_rest", 32'(resttime), 0);
        check("mid_rst_timeout", 32'(timeout), 0);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_foul", 32'(foul), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
